// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> multiply/divide sequencer interface: op request, flush, stall
// and the architectural HI/LO read-out.
interface muldiv_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        flush;
    logic        stall;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, in0, in1, flush,
        input  stall, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, in0, in1, flush,
        output stall, done, dbz, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// One-cycle multiply, 32-step restoring divide, pipeline stall while busy.
module muldiv_ctrl (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  bus
);
    localparam int unsigned DIV_STEPS = 32;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned CNT_W     = $clog2(DIV_STEPS);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q;
    logic [XLEN-1:0]     hi_q;
    logic [XLEN-1:0]     lo_q;
    logic                done_q;
    logic                dbz_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [XLEN-1:0]     opa_q;
    logic [XLEN-1:0]     opb_q;
    logic                mul_signed_q;
    logic                q_neg_q;
    logic                r_neg_q;
    logic [2*XLEN-1:0]   rq_q;

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    // Operand preparation at acceptance: magnitudes and sign bits for signed DIV.
    logic            div_signed_c;
    logic            in0_neg_c;
    logic            in1_neg_c;
    logic [XLEN-1:0] in0_abs_c;
    logic [XLEN-1:0] in1_abs_c;

    always_comb begin
        div_signed_c = (bus.op == OP_DIV);
        in0_neg_c    = div_signed_c & bus.in0[XLEN-1];
        in1_neg_c    = div_signed_c & bus.in1[XLEN-1];
        in0_abs_c    = in0_neg_c ? neg_w(bus.in0) : bus.in0;
        in1_abs_c    = in1_neg_c ? neg_w(bus.in1) : bus.in1;
    end

    // Full 64-bit product; sign-extending to 64 bits makes one multiplier serve both.
    logic [2*XLEN-1:0] mul_a_c;
    logic [2*XLEN-1:0] mul_b_c;
    logic [2*XLEN-1:0] product_c;

    always_comb begin
        mul_a_c   = {{XLEN{mul_signed_q & opa_q[XLEN-1]}}, opa_q};
        mul_b_c   = {{XLEN{mul_signed_q & opb_q[XLEN-1]}}, opb_q};
        product_c = mul_a_c * mul_b_c;
    end

    // One restoring step: bit 32 of the 33-bit difference is the borrow.
    logic [XLEN:0]     rem_shift_c;
    logic [XLEN:0]     diff_c;
    logic [2*XLEN-1:0] rq_next_c;
    logic [XLEN-1:0]   quo_fix_c;
    logic [XLEN-1:0]   rem_fix_c;

    always_comb begin
        rem_shift_c = rq_q[2*XLEN-1:XLEN-1];
        diff_c      = rem_shift_c - {1'b0, opb_q};
        if (diff_c[XLEN]) begin
            rq_next_c = {rem_shift_c[XLEN-1:0], rq_q[XLEN-2:0], 1'b0};
        end else begin
            rq_next_c = {diff_c[XLEN-1:0], rq_q[XLEN-2:0], 1'b1};
        end
        quo_fix_c = q_neg_q ? neg_w(rq_next_c[XLEN-1:0]) : rq_next_c[XLEN-1:0];
        rem_fix_c = r_neg_q ? neg_w(rq_next_c[2*XLEN-1:XLEN])
                            : rq_next_c[2*XLEN-1:XLEN];
    end

    assign bus.stall = ((state_q == S_IDLE) && bus.start && !bus.flush && (bus.op <= OP_DIVU))
                     || (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.done  = done_q;
    assign bus.dbz   = dbz_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hi_q         <= '0;
            lo_q         <= '0;
            done_q       <= 1'b0;
            dbz_q        <= 1'b0;
            cnt_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            mul_signed_q <= 1'b0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            rq_q         <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                opa_q        <= bus.in0;
                                opb_q        <= bus.in1;
                                mul_signed_q <= (bus.op == OP_MULT);
                                state_q      <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (bus.in1 == '0) begin
                                    done_q  <= 1'b1;
                                    dbz_q   <= 1'b1;
                                    state_q <= S_DONE;
                                end else begin
                                    rq_q    <= {{XLEN{1'b0}}, in0_abs_c};
                                    opb_q   <= in1_abs_c;
                                    q_neg_q <= in0_neg_c ^ in1_neg_c;
                                    r_neg_q <= in0_neg_c;
                                    cnt_q   <= '0;
                                    state_q <= S_DIV;
                                end
                            end
                            OP_MTHI: hi_q <= bus.in0;
                            OP_MTLO: lo_q <= bus.in0;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        hi_q    <= product_c[2*XLEN-1:XLEN];
                        lo_q    <= product_c[XLEN-1:0];
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        rq_q <= rq_next_c;
                        if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
                            lo_q    <= quo_fix_c;
                            hi_q    <= rem_fix_c;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                // Result already committed; the held start belongs to the finished op.
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
